// File: rtl/ad9643_regmap_clkdiv.sv
// rtl/ad9643_regmap_clkdiv.sv - AD9643 SPI register map, shadowed sample-clock divider and SDIO pad buffer
module ad9643_regmap_clkdiv (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [12:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic [7:0]  clock_divide,
    output logic        out_clk_p,
    output logic        out_clk_n,
    input  logic        dir,
    input  logic        miso,
    output logic        mosi,
    inout  wire         sdio
);

    localparam logic [12:0] ADDR_SPI_CFG  = 13'h000;
    localparam logic [12:0] ADDR_CHIP_ID  = 13'h001;
    localparam logic [12:0] ADDR_GRADE    = 13'h002;
    localparam logic [12:0] ADDR_CHAN_IDX = 13'h005;
    localparam logic [12:0] ADDR_PWR_MODE = 13'h008;
    localparam logic [12:0] ADDR_CLK_DIV  = 13'h00B;
    localparam logic [12:0] ADDR_TEST     = 13'h00D;
    localparam logic [12:0] ADDR_OUT_MODE = 13'h014;
    localparam logic [12:0] ADDR_TRANSFER = 13'h0FF;

    localparam logic [7:0] SPI_CFG_RST = 8'h18;
    localparam logic [7:0] CHIP_ID     = 8'h82;
    localparam logic [7:0] CHIP_GRADE  = 8'h20;

    logic [7:0] spi_cfg;
    logic [1:0] chan_idx;
    logic [7:0] pwr_mode;
    logic [7:0] clk_div_master;
    logic [7:0] test_mode;
    logic [7:0] out_mode;

    logic       soft_reset;
    logic       transfer;
    logic       ratio_load;

    assign soft_reset = wr_en && (addr == ADDR_SPI_CFG) && (wdata[5] || wdata[2]);
    assign transfer   = wr_en && (addr == ADDR_TRANSFER) && wdata[0];
    assign ratio_load = soft_reset || transfer;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            spi_cfg        <= SPI_CFG_RST;
            chan_idx       <= 2'b11;
            pwr_mode       <= 8'h00;
            clk_div_master <= 8'h00;
            test_mode      <= 8'h00;
            out_mode       <= 8'h00;
            clock_divide   <= 8'h00;
        end else if (soft_reset) begin
            spi_cfg        <= SPI_CFG_RST;
            chan_idx       <= 2'b11;
            pwr_mode       <= 8'h00;
            clk_div_master <= 8'h00;
            test_mode      <= 8'h00;
            out_mode       <= 8'h00;
            clock_divide   <= 8'h00;
        end else if (wr_en) begin
            case (addr)
                ADDR_SPI_CFG:  spi_cfg        <= wdata;
                ADDR_CHAN_IDX: chan_idx       <= wdata[1:0];
                ADDR_PWR_MODE: pwr_mode       <= wdata;
                ADDR_CLK_DIV:  clk_div_master <= wdata;
                ADDR_TEST:     test_mode      <= wdata;
                ADDR_OUT_MODE: out_mode       <= wdata;
                // transfer bit is a strobe only; nothing is stored at 0x0FF
                ADDR_TRANSFER: if (wdata[0]) clock_divide <= clk_div_master;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (addr)
            ADDR_SPI_CFG:  rdata = spi_cfg;
            ADDR_CHIP_ID:  rdata = CHIP_ID;
            ADDR_GRADE:    rdata = CHIP_GRADE;
            ADDR_CHAN_IDX: rdata = {6'b0, chan_idx};
            ADDR_PWR_MODE: rdata = pwr_mode;
            ADDR_CLK_DIV:  rdata = clk_div_master;
            ADDR_TEST:     rdata = test_mode;
            ADDR_OUT_MODE: rdata = out_mode;
            default:       rdata = 8'h00;
        endcase
    end

    // Divider: ratio N = n_m1 + 1; output high while cnt < ceil(N/2), registered one edge later
    logic [2:0] n_m1;
    logic [2:0] cnt;
    logic [3:0] half_n;
    logic       div_q;

    assign n_m1   = clock_divide[2:0];
    assign half_n = ({1'b0, n_m1} + 4'd2) >> 1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= 3'd0;
            div_q <= 1'b0;
        end else if (ratio_load) begin
            cnt   <= 3'd0;
            div_q <= 1'b0;
        end else begin
            div_q <= ({1'b0, cnt} < half_n);
            cnt   <= (cnt == n_m1) ? 3'd0 : cnt + 3'd1;
        end
    end

    assign out_clk_p = (n_m1 == 3'd0) ? (clk & resetn) : div_q;
    assign out_clk_n = ~out_clk_p;

    assign sdio = dir ? 1'bz : miso;
    assign mosi = sdio;

endmodule

// File: tb/tb_ad9643_regmap_clkdiv.sv
// tb/tb_ad9643_regmap_clkdiv.sv - scoreboard bench for ad9643_regmap_clkdiv with a behavioural register/divider model
module tb_ad9643_regmap_clkdiv;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_en = 1'b0;
    logic [12:0] addr = 13'h0;
    logic [7:0]  wdata = 8'h0;
    logic [7:0]  rdata;
    logic [7:0]  clock_divide;
    logic        out_clk_p;
    logic        out_clk_n;
    logic        dir = 1'b1;
    logic        miso = 1'b0;
    logic        mosi;
    wire         sdio;
    logic        sdio_drv = 1'b0;
    logic        sdio_en = 1'b0;

    assign sdio = sdio_en ? sdio_drv : 1'bz;

    always #5 clk = ~clk;

    ad9643_regmap_clkdiv dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .clock_divide(clock_divide), .out_clk_p(out_clk_p),
        .out_clk_n(out_clk_n), .dir(dir), .miso(miso), .mosi(mosi), .sdio(sdio)
    );

    typedef struct {
        logic [12:0] a;
        logic [7:0]  rd;
        logic [7:0]  div;
        logic        hi;
        logic        lo;
        logic        mosi;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad = 0;
    bit    tb_valid = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents by address, active ratio and cycles since the last ratio restart
    logic [7:0] mreg [int];
    logic [7:0] m_active;
    int         m_k;

    function automatic void model_reset();
        mreg.delete();
        mreg[13'h000] = 8'h18;
        mreg[13'h005] = 8'h03;
        mreg[13'h008] = 8'h00;
        mreg[13'h00B] = 8'h00;
        mreg[13'h00D] = 8'h00;
        mreg[13'h014] = 8'h00;
        m_active = 8'h00;
        m_k = 0;
    endfunction

    function automatic logic [7:0] model_read(input logic [12:0] a);
        if (a == 13'h001) return 8'h82;
        if (a == 13'h002) return 8'h20;
        if (mreg.exists(int'(a))) return mreg[int'(a)];
        return 8'h00;
    endfunction

    function automatic void model_edge(input logic rn, input logic w, input logic [12:0] a, input logic [7:0] d);
        bit restart = 0;
        if (!rn) begin
            model_reset();
            return;
        end
        if (w) begin
            if (a == 13'h000 && (d[5] || d[2])) begin
                model_reset();
                restart = 1;
            end else if (a == 13'h0FF) begin
                if (d[0]) begin
                    m_active = mreg[13'h00B];
                    restart = 1;
                end
            end else if (a == 13'h005) begin
                mreg[13'h005] = d & 8'h03;
            end else if (mreg.exists(int'(a))) begin
                mreg[int'(a)] = d;
            end
        end
        m_k = restart ? 0 : m_k + 1;
    endfunction

    function automatic logic model_div_out();
        int n = int'(m_active[2:0]) + 1;
        if (m_k == 0) return 1'b0;
        return ((m_k - 1) % n) < ((n + 1) / 2);
    endfunction

    logic        cur_rn = 1'b0;
    logic        cur_w = 1'b0;
    logic [12:0] cur_a = 13'h0;
    logic [7:0]  cur_d = 8'h0;

    task automatic cycle(input logic rn, input logic w, input logic [12:0] a, input logic [7:0] d);
        item_t it;
        int    n;
        @(posedge clk);
        model_edge(cur_rn, cur_w, cur_a, cur_d);
        #1;
        resetn = rn; wr_en = w; addr = a; wdata = d;
        dir = 1'($urandom_range(0, 1));
        miso = 1'($urandom_range(0, 1));
        sdio_drv = 1'($urandom_range(0, 1));
        sdio_en = dir;
        if (!rn) model_reset();
        cur_rn = rn; cur_w = w; cur_a = a; cur_d = d;
        n = int'(m_active[2:0]) + 1;
        it.a    = a;
        it.rd   = model_read(a);
        it.div  = m_active;
        it.hi   = (n == 1) ? rn : model_div_out();
        it.lo   = (n == 1) ? 1'b0 : model_div_out();
        it.mosi = dir ? sdio_drv : miso;
        q.push_back(it);
        tb_valid = 1;
    endtask

    task automatic wr(input logic [12:0] a, input logic [7:0] d);
        cycle(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [12:0] a, input int cycles);
        for (int i = 0; i < cycles; i++) cycle(1'b1, 1'b0, a, 8'($urandom));
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(posedge clk);
            #3;
            if (tb_valid) begin
                if (q.size() == 0) begin
                    chk("queue_underflow", 8'd0, 8'd1);
                end else begin
                    it = q.pop_front();
                    chk($sformatf("rdata@%h", it.a), rdata, it.rd);
                    chk("clock_divide", clock_divide, it.div);
                    chk("out_clk_p_high_half", {7'b0, out_clk_p}, {7'b0, it.hi});
                    chk("out_clk_n_high_half", {7'b0, out_clk_n}, {7'b0, ~it.hi});
                    chk("mosi", {7'b0, mosi}, {7'b0, it.mosi});
                    @(negedge clk);
                    #1;
                    chk("out_clk_p_low_half", {7'b0, out_clk_p}, {7'b0, it.lo});
                    chk("out_clk_n_low_half", {7'b0, out_clk_n}, {7'b0, ~it.lo});
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int r;
        logic [12:0] a;
        logic [7:0] d;
        logic [12:0] addrs [10];
        addrs = '{13'h000, 13'h001, 13'h002, 13'h005, 13'h008,
                  13'h00B, 13'h00D, 13'h014, 13'h0FF, 13'h1234};
        model_reset();

        cycle(1'b0, 1'b0, 13'h000, 8'h00);
        cycle(1'b0, 1'b0, 13'h000, 8'h00);
        rd(13'h000, 2); rd(13'h001, 2); rd(13'h002, 2); rd(13'h005, 2); rd(13'h00B, 2);

        wr(13'h001, 8'h55); wr(13'h1234, 8'h55);
        rd(13'h001, 1); rd(13'h1234, 1);
        wr(13'h005, 8'hFF); rd(13'h005, 2);

        wr(13'h00B, 8'h03); rd(13'h00B, 2);
        wr(13'h0FF, 8'h01); rd(13'h0FF, 10);

        wr(13'h00B, 8'h02); wr(13'h0FF, 8'h01); rd(13'h0FF, 8);

        wr(13'h008, 8'hAA); wr(13'h00B, 8'h07); wr(13'h0FF, 8'h01); rd(13'h008, 5);
        wr(13'h000, 8'h3C); rd(13'h008, 2); rd(13'h000, 2); rd(13'h00B, 2);

        wr(13'h00B, 8'h07); wr(13'h0FF, 8'h01); rd(13'h00B, 3);
        cycle(1'b0, 1'b0, 13'h00B, 8'h00);
        cycle(1'b0, 1'b0, 13'h000, 8'h00);
        rd(13'h00B, 3);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            a = ($urandom_range(0, 3) == 0) ? 13'($urandom) : addrs[$urandom_range(0, 9)];
            d = 8'($urandom);
            if (r < 45) begin
                cycle(1'b1, 1'b0, a, d);
            end else if (r < 85) begin
                if (a == 13'h000) d = d & 8'hDB;
                if (a == 13'h0FF) a = 13'h00B;
                wr(a, d);
            end else if (r < 93) begin
                wr(13'h0FF, d);
            end else if (r < 97) begin
                wr(13'h000, d | 8'h04);
            end else begin
                cycle(1'b0, 1'b0, a, d);
            end
        end

        @(negedge clk);
        #2;
        tb_valid = 0;
        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
